// File: rtl/dw_lp_cntr_cmd_seq.sv
// Command sequencer driving the control inputs of dw_lp_cntr_updn_df.
// Accepts LOAD / UP_TO / DN_TO / HOLD commands and reports completion.
//
//  state | meaning
//  IDLE  | waiting for a command, cmd_ready high
//  LOAD  | cntr_ld_n low for one cycle
//  RUN   | counter enabled until term_count_n falls
//  HOLD  | counter frozen while hold_cnt runs down
module dw_lp_cntr_cmd_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   output logic             cntr_ld_n,
   output logic [WIDTH-1:0] cntr_ld_count,
   output logic             cntr_enable,
   output logic             cntr_up_dn,
   output logic [WIDTH-1:0] cntr_term_val,
   input  logic [WIDTH-1:0] cntr_count,
   input  logic             cntr_term_count_n,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] done_count,
   output logic             aborted
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_HOLD} state_t;

   localparam logic [1:0]       OP_LOAD = 2'd0;
   localparam logic [1:0]       OP_UP   = 2'd1;
   localparam logic [1:0]       OP_DN   = 2'd2;
   localparam logic [1:0]       OP_HOLD = 2'd3;
   localparam logic [WIDTH-1:0] ONE     = 1;

   state_t           state;
   logic [WIDTH-1:0] hold_cnt;

   assign cmd_ready   = (state == ST_IDLE) && !rst;
   assign busy        = (state != ST_IDLE);
   // Enable follows term_count_n directly so the counter never overshoots.
   assign cntr_enable = (state == ST_RUN) && cntr_term_count_n && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         cntr_ld_n     <= 1'b1;
         cntr_ld_count <= '0;
         cntr_up_dn    <= 1'b1;
         cntr_term_val <= '0;
         done          <= 1'b0;
         done_count    <= '0;
         aborted       <= 1'b0;
         hold_cnt      <= '0;
      end else begin
         cntr_ld_n <= 1'b1;
         done      <= 1'b0;
         aborted   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op)
                     OP_LOAD: begin
                        cntr_ld_count <= cmd_data;
                        cntr_ld_n     <= 1'b0;
                        state         <= ST_LOAD;
                     end
                     OP_UP, OP_DN: begin
                        cntr_term_val <= cmd_data;
                        cntr_up_dn    <= (cmd_op == OP_UP);
                        state         <= ST_RUN;
                     end
                     OP_HOLD: begin
                        hold_cnt <= cmd_data;
                        state    <= ST_HOLD;
                     end
                     default: state <= ST_IDLE;
                  endcase
               end
            end
            ST_LOAD: begin
               state <= ST_IDLE;
               if (abort) begin
                  aborted <= 1'b1;
               end else begin
                  done       <= 1'b1;
                  done_count <= cntr_ld_count;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  aborted <= 1'b1;
               end else if (!cntr_term_count_n) begin
                  state      <= ST_IDLE;
                  done       <= 1'b1;
                  done_count <= cntr_count;
               end
            end
            ST_HOLD: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  aborted <= 1'b1;
               end else if (hold_cnt == '0) begin
                  state      <= ST_IDLE;
                  done       <= 1'b1;
                  done_count <= cntr_count;
               end else begin
                  hold_cnt <= hold_cnt - ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
